// File: rtl/fetch_pc_gen.sv
// IF-stage PC generator and IF/ID pipeline register for the RV32I 5-stage core.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        predict_taken,
  input  logic [31:0] predict_target,
  output logic [31:0] pc_o,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_pred_taken,
  output logic [31:0] ifid_pred_target,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] kill_pc;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        hold_taken;
  logic [31:0] hold_target;
  logic [31:0] redir_aligned;
  logic        redirect_lsb_unused;
  logic        accept;
  logic        ifid_load;

  assign redir_aligned       = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign pc_o      = pc;
  assign imem_addr = pc;
  assign imem_req  = (state == WAIT);

  // A live response in WAIT that is neither killed nor redirected.
  assign accept    = (state == WAIT) && imem_rvalid && !kill && !redirect_valid;
  assign ifid_load = !stall_i && (accept || ((state == HOLD) && !redirect_valid));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      kill_pc     <= '0;
      hold_pc     <= '0;
      hold_instr  <= '0;
      hold_taken  <= 1'b0;
      hold_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= WAIT;
          if (redirect_valid) pc <= redir_aligned;
        end
        WAIT: begin
          if (redirect_valid) begin
            // The address must stay put while a request is in flight, so a
            // redirect without a response is deferred through the kill flag.
            if (imem_rvalid) begin
              pc   <= redir_aligned;
              kill <= 1'b0;
            end else begin
              kill    <= 1'b1;
              kill_pc <= redir_aligned;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              pc   <= kill_pc;
              kill <= 1'b0;
            end else if (stall_i) begin
              hold_pc     <= pc;
              hold_instr  <= imem_rdata;
              hold_taken  <= predict_taken;
              hold_target <= predict_target;
              state       <= HOLD;
            end else begin
              pc <= predict_target;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= redir_aligned;
            state <= WAIT;
          end else if (!stall_i) begin
            pc    <= hold_target;
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_valid       <= 1'b0;
      ifid_pc          <= '0;
      ifid_instr       <= '0;
      ifid_pred_taken  <= 1'b0;
      ifid_pred_target <= '0;
    end else if (redirect_valid) begin
      ifid_valid <= 1'b0;
    end else if (ifid_load) begin
      ifid_valid <= 1'b1;
      if (state == HOLD) begin
        ifid_pc          <= hold_pc;
        ifid_instr       <= hold_instr;
        ifid_pred_taken  <= hold_taken;
        ifid_pred_target <= hold_target;
      end else begin
        ifid_pc          <= pc;
        ifid_instr       <= imem_rdata;
        ifid_pred_taken  <= predict_taken;
        ifid_pred_target <= predict_target;
      end
    end else if (!stall_i) begin
      ifid_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (ifid_load)      perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- IF-stage PC generator and IF/ID register for the RV32I 5-stage core.
- Holds the fetch PC and drives it to the branch predictor and instruction memory.
- Selects the next PC from the predictor target or the EX-stage redirect, and delivers fetched instructions with their prediction tags to ID.
- Supports variable-latency instruction memory with one request outstanding; handles stalls and flushes.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard unit: freeze the IF/ID register and stop advancing the PC.
- redirect_valid  in  1  EX stage: mispredict or jump; flush and refetch.
- redirect_pc  in  32  correct target from EX.
- predict_taken  in  1  predictor result for pc_o.
- predict_target  in  32  predictor next PC for pc_o (PC+4 when not taken).
- pc_o  out  32  current fetch PC, to predictor PC input.
- imem_req  out  1  instruction fetch request, level signal.
- imem_addr  out  32  fetch address, always equal to pc_o.
- imem_rvalid  in  1  response valid; at most one per request.
- imem_rdata  in  32  instruction word.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_pc  out  32  PC of the IF/ID instruction.
- ifid_instr  out  32  instruction word.
- ifid_pred_taken  out  1  prediction captured with the instruction.
- ifid_pred_target  out  32  predicted next PC captured with the instruction.
- perf_fetch_cnt  out  32  see Optional Feature.
- perf_redirect_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_o=RESET_PC, imem_req=0, all ifid_* outputs 0, kill flag 0, state IDLE.
- FSM states: IDLE, WAIT, HOLD.
- IDLE: the cycle after reset deasserts, go to WAIT with imem_req=1.
- WAIT (imem_req=1):
  - pc_o/imem_addr stay stable until imem_rvalid.
  - On rvalid with kill=0 and stall_i=0:
    - load IF/ID {1, pc_o, imem_rdata, predict_taken, predict_target};
    - pc_o <= predict_target; stay in WAIT and request again next cycle.
    - Fetch throughput is 1 instruction per cycle when rvalid returns every cycle.
  - On rvalid with kill=0 and stall_i=1:
    - capture {pc, instr, pred_taken, pred_target} into the hold buffer;
    - imem_req=0; go to HOLD; IF/ID unchanged.
  - On rvalid with kill=1: discard the response; pc_o <= saved redirect PC; kill <= 0; stay in WAIT.
- HOLD (imem_req=0): when stall_i=0, move the hold buffer into IF/ID, pc_o <= buffered pred_target, go to WAIT.
- redirect_valid has the highest priority:
  - Always: ifid_valid <= 0 on the next edge (bubble), regardless of stall_i.
  - In WAIT without a same-cycle rvalid: set kill=1 and save redirect_pc. The address may not change mid-request.
  - In WAIT with a same-cycle rvalid: drop the response; pc_o <= redirect_pc; no kill.
  - In HOLD or IDLE: drop the buffer; pc_o <= redirect_pc; go to WAIT.
  - A second redirect while kill=1 overwrites the saved PC.
- redirect_pc[1:0] is forced to 2'b00 when loaded.
- stall_i=1 without redirect: IF/ID holds all fields.
- PC arithmetic is 32-bit and wraps at 32'hFFFF_FFFC → predictor PC+4 = 0. No special handling.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetch_cnt increments on each IF/ID load with valid=1.
  - perf_redirect_cnt increments on each cycle with redirect_valid=1.
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both outputs are constant 0 and no counter flops are built.

Test Plan:
1. Reset, imem returns rvalid 1 cycle after each req, predictor not taken → pc_o sequence 0,4,8,C; ifid_pc follows one response later with ifid_valid=1.
2. At pc=0x10, predict_taken=1, predict_target=0x40 → next pc_o=0x40; ifid_pred_taken=1, ifid_pred_target=0x40.
3. Redirect to 0x203 during a 3-cycle imem wait at 0x8 → the 0x8 response is dropped; next imem_addr=0x200; ifid_valid=0 for the flush cycle.
4. Redirect and rvalid in the same cycle → response dropped; imem_addr=redirect_pc next cycle; no extra request at the old PC.
5. stall_i=1 for 4 cycles while a response arrives → IF/ID stable; imem_req=0 in HOLD; after release the buffered instruction appears with its original pc, then fetch resumes.
6. With FETCH_PERF_CNT_EN: 10 fetches and 2 redirects → perf_fetch_cnt equals the count of valid IF/ID loads (10 minus any loads dropped by the redirects); perf_redirect_cnt=2. Without the macro both read 0.
